// File: rtl/fsm_seq_pkg.sv
// Shared types and control-store entry layout for the fsm_sequencer block.
// Entry packing, MSB to LSB: {ctrl, next, br_tgt, br_en, last}.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } seq_state_e;

    localparam int unsigned LastOff  = 0;
    localparam int unsigned BrEnOff  = 1;
    localparam int unsigned BrTgtOff = 2;

    function automatic int unsigned next_off(input int unsigned state_w);
        return 2 + state_w;
    endfunction

    function automatic int unsigned ctrl_off(input int unsigned state_w);
        return 2 + 2 * state_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned ctrl_w, input int unsigned state_w);
        return ctrl_w + 2 * state_w + 2;
    endfunction

endpackage

// File: rtl/fsm_sequencer_if.sv
// Host/datapath-facing signal bundle of fsm_sequencer.
// FSM_SEQ_STALL_EN adds the stall input.
interface fsm_sequencer_if
    import fsm_seq_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned CTRL_W  = 16,
    parameter int unsigned CNT_W   = 16
);
    logic                                 start;
    logic                                 busy;
    logic                                 done;
    logic                                 err;
    logic                                 cond;
    logic [CTRL_W-1:0]                    ctrl_o;
    logic [STATE_W-1:0]                   state_o;
    logic [CNT_W-1:0]                     steps_o;
    logic                                 prog_we;
    logic [STATE_W-1:0]                   prog_addr;
    logic [entry_w(CTRL_W, STATE_W)-1:0]  prog_data;
`ifdef FSM_SEQ_STALL_EN
    logic                                 stall;

    modport master (
        output start, cond, prog_we, prog_addr, prog_data, stall,
        input  busy, done, err, ctrl_o, state_o, steps_o
    );
    modport slave (
        input  start, cond, prog_we, prog_addr, prog_data, stall,
        output busy, done, err, ctrl_o, state_o, steps_o
    );
`else
    modport master (
        output start, cond, prog_we, prog_addr, prog_data,
        input  busy, done, err, ctrl_o, state_o, steps_o
    );
    modport slave (
        input  start, cond, prog_we, prog_addr, prog_data,
        output busy, done, err, ctrl_o, state_o, steps_o
    );
`endif
endinterface

// File: rtl/fsm_seq_store.sv
// Register-array control store: async clear to the default entry (last=1),
// one write port, one combinational read port. Out-of-range addresses are ignored.
module fsm_seq_store
    import fsm_seq_pkg::*;
#(
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned CTRL_W     = 16,
    localparam int unsigned EntryW    = entry_w(CTRL_W, STATE_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [STATE_W-1:0] waddr_i,
    input  logic [EntryW-1:0]  wdata_i,
    input  logic [STATE_W-1:0] raddr_i,
    output logic [EntryW-1:0]  rdata_o
);
    // Only the last flag is set, so an unprogrammed run ends after one step.
    localparam logic [EntryW-1:0] DefaultEntry = EntryW'(1);

    logic [EntryW-1:0] mem_q [NUM_STATES];

    // Storage: clear on reset, single write port with full-width address decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_STATES); i++) begin
                mem_q[i] <= DefaultEntry;
            end
        end else if (we_i) begin
            for (int i = 0; i < int'(NUM_STATES); i++) begin
                if (waddr_i == STATE_W'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    // Read mux: addresses beyond the store return the default entry.
    always_comb begin
        rdata_o = DefaultEntry;
        for (int i = 0; i < int'(NUM_STATES); i++) begin
            if (raddr_i == STATE_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/fsm_sequencer.sv
// Programmable control-word sequencer feeding the datapath one store entry per cycle.
// Build option: FSM_SEQ_STALL_EN adds a stall input that freezes the RUN state.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned CNT_W      = 16
) (
    input logic            clk,
    input logic            reset,
    fsm_sequencer_if.slave bus
);
    localparam int unsigned EntryW  = entry_w(CTRL_W, STATE_W);
    localparam int unsigned NextOff = next_off(STATE_W);
    localparam int unsigned CtrlOff = ctrl_off(STATE_W);

    seq_state_e         state_q, state_d;
    logic [STATE_W-1:0] pc_q, pc_d;
    logic [STATE_W-1:0] tgt;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               err_q, err_d;
    logic [EntryW-1:0]  entry;
    logic               store_we;
    logic               stall;
    logic               busy;
    logic               done;
    logic [CTRL_W-1:0]  ctrl;

`ifdef FSM_SEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    fsm_seq_store #(
        .STATE_W   (STATE_W),
        .NUM_STATES(NUM_STATES),
        .CTRL_W    (CTRL_W)
    ) u_store (
        .clk    (clk),
        .reset  (reset),
        .we_i   (store_we),
        .waddr_i(bus.prog_addr),
        .wdata_i(bus.prog_data),
        .raddr_i(pc_q),
        .rdata_o(entry)
    );

    // State, program counter, step counter and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    // Next-state, next-pc selection and per-state outputs.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        steps_d  = steps_q;
        err_d    = err_q;
        busy     = 1'b0;
        done     = 1'b0;
        ctrl     = '0;
        store_we = 1'b0;
        tgt      = (entry[BrEnOff] && bus.cond) ? entry[BrTgtOff +: STATE_W]
                                                : entry[NextOff +: STATE_W];
        unique case (state_q)
            StIdle: begin
                // Store is writable only here; a same-cycle start sees the new entry.
                store_we = bus.prog_we;
                if (bus.start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            StRun: begin
                busy = 1'b1;
                ctrl = entry[CtrlOff +: CTRL_W];
                // A stalled cycle defers the branch decision to the next free cycle.
                if (!stall) begin
                    if (steps_q != '1) begin
                        steps_d = steps_q + CNT_W'(1);
                    end
                    if (entry[LastOff]) begin
                        state_d = StFin;
                    end else if (32'(tgt) >= NUM_STATES) begin
                        // Bad target is never loaded, so it is never executed.
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        pc_d = tgt;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err     = err_q;
    assign bus.ctrl_o  = ctrl;
    assign bus.state_o = pc_q;
    assign bus.steps_o = steps_q;

endmodule
